// File: rtl/tournament_predictor_gen2_pkg.sv
// Shared definitions for the tournament predictor: branch kinds, FSM states,
// and counter helpers that work for any counter width up to CTR_MAX_W.
package tournament_predictor_gen2_pkg;

    localparam int unsigned CTR_MAX_W = 4;

    typedef enum logic [2:0] {
        KIND_NOT_JUMP      = 3'd0,
        KIND_DIRECT_JUMP   = 3'd1,
        KIND_JUMP          = 3'd2,
        KIND_CALL          = 3'd3,
        KIND_RET           = 3'd4,
        KIND_INDIRECT_JUMP = 3'd5
    } kind_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Saturating step: up=1 increments towards 2**ctr_w-1, up=0 decrements towards 0.
    function automatic logic [CTR_MAX_W-1:0] sat_step(input logic [CTR_MAX_W-1:0] ctr,
                                                      input logic                 up,
                                                      input int unsigned          ctr_w);
        logic [CTR_MAX_W-1:0] max_v;
        max_v = CTR_MAX_W'((32'd1 << ctr_w) - 32'd1);
        if (up) begin
            return (ctr >= max_v) ? max_v : ctr + CTR_MAX_W'(1);
        end
        return (ctr == '0) ? '0 : ctr - CTR_MAX_W'(1);
    endfunction

    // Weakly-not-taken / weakly-bimodal value used by the table-clear sweep.
    function automatic logic [CTR_MAX_W-1:0] weak_init(input int unsigned ctr_w);
        return CTR_MAX_W'((32'd1 << (ctr_w - 32'd1)) - 32'd1);
    endfunction

endpackage

// File: rtl/tournament_predictor_gen2_pht_bank.sv
// One pattern-history table: 2**IDX_W counters, one write port (sweep or update)
// and one read port that forwards a same-index write in the same cycle.
module tournament_predictor_gen2_pht_bank
    import tournament_predictor_gen2_pkg::*;
#(
    parameter int unsigned IDX_W = 12,
    parameter int unsigned CTR_W = 2
) (
    input  logic             clk,
    input  logic             i_init,
    input  logic [IDX_W-1:0] i_init_idx,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [CTR_W-1:0] i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [CTR_W-1:0] o_rdata_c
);

    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam logic [CTR_W-1:0] WEAK = CTR_W'(weak_init(CTR_W));

    logic [CTR_W-1:0] r_mem [DEPTH];
    logic             w_fwd;

    // Sweep owns the write port while it runs.
    always_ff @(posedge clk) begin
        if (i_init) begin
            r_mem[i_init_idx] <= WEAK;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign w_fwd     = i_we && !i_init && (i_waddr == i_raddr);
    assign o_rdata_c = w_fwd ? i_wdata : r_mem[i_raddr];

endmodule

// File: rtl/tournament_predictor_gen2.sv
// Tournament direction predictor: bimodal, gshare and chooser tables, speculative
// GHR with mispredict recovery, one-cycle registered responses, post-reset sweep.
module tournament_predictor_gen2
    import tournament_predictor_gen2_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 30,
    parameter int unsigned IDX_W      = 12,
    parameter int unsigned CTR_W      = 2,
    parameter int unsigned GH_W       = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic                  pdc_valid,
    input  logic [ADDR_WIDTH-1:0] pc,
    input  logic [2:0]            kind_pdc,
    output logic                  pdc_valid_o,
    output logic                  taken_pdc,
    output logic                  choice_b_g,
    output logic [CTR_W-1:0]      ctr_b_o,
    output logic [CTR_W-1:0]      ctr_g_o,
    output logic [CTR_W-1:0]      ctr_c_o,
    output logic [GH_W-1:0]       ghr_o,
    input  logic                  update_en,
    input  logic [ADDR_WIDTH-1:0] pc_ex,
    input  logic [2:0]            kind_ex,
    input  logic                  taken_real,
    input  logic                  mispredict,
    input  logic [GH_W-1:0]       ghr_ex,
    input  logic [CTR_W-1:0]      ctr_b_ex,
    input  logic [CTR_W-1:0]      ctr_g_ex,
    input  logic [CTR_W-1:0]      ctr_c_ex
);

    localparam int unsigned MSB = CTR_W - 1;

    state_e           r_state, w_state_next;
    logic [IDX_W-1:0] r_idx, w_idx_next;
    logic             r_ready, w_ready_next;
    logic             w_init, w_run;

    logic [GH_W-1:0]  r_ghr, w_ghr_next;
    logic             r_valid_o, r_taken, r_choice;
    logic [CTR_W-1:0] r_ctr_b, r_ctr_g, r_ctr_c;
    logic [GH_W-1:0]  r_ghr_o;

    logic             w_upd, w_c_we, w_g_correct;
    logic [IDX_W-1:0] w_ub_idx, w_ug_idx, w_rb_idx, w_rg_idx;
    logic [CTR_W-1:0] w_b_wdata, w_g_wdata, w_c_wdata;
    logic [CTR_W-1:0] w_b_rd, w_g_rd, w_c_rd;
    logic             w_is_dj, w_is_uncond, w_pred_dj, w_taken_c;
    logic             w_unused_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_INIT;
            r_idx   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_ready <= w_ready_next;
        end
    end

    // Sweep one index per cycle, then run forever until the next reset.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_ready_next = r_ready;
        w_init       = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_init     = 1'b1;
                w_idx_next = r_idx + IDX_W'(1);
                if (r_idx == '1) begin
                    w_state_next = ST_RUN;
                    w_ready_next = 1'b1;
                end
            end
            ST_RUN: w_ready_next = 1'b1;
            default: w_state_next = ST_INIT;
        endcase
    end

    assign w_run = (r_state == ST_RUN);

    // Training writes come straight from the snapshots carried down the pipe.
    assign w_upd       = w_run && update_en && (kind_ex == KIND_DIRECT_JUMP);
    assign w_ub_idx    = pc_ex[IDX_W-1:0];
    assign w_ug_idx    = w_ub_idx ^ IDX_W'(ghr_ex);
    assign w_g_correct = (ctr_g_ex[MSB] == taken_real);
    assign w_c_we      = w_upd && (ctr_b_ex[MSB] != ctr_g_ex[MSB]);
    assign w_b_wdata   = CTR_W'(sat_step(CTR_MAX_W'(ctr_b_ex), taken_real, CTR_W));
    assign w_g_wdata   = CTR_W'(sat_step(CTR_MAX_W'(ctr_g_ex), taken_real, CTR_W));
    assign w_c_wdata   = CTR_W'(sat_step(CTR_MAX_W'(ctr_c_ex), w_g_correct, CTR_W));

    assign w_rb_idx = pc[IDX_W-1:0];
    assign w_rg_idx = w_rb_idx ^ IDX_W'(r_ghr);

    tournament_predictor_gen2_pht_bank #(.IDX_W(IDX_W), .CTR_W(CTR_W)) u_pht_b (
        .clk(clk), .i_init(w_init), .i_init_idx(r_idx), .i_we(w_upd),
        .i_waddr(w_ub_idx), .i_wdata(w_b_wdata), .i_raddr(w_rb_idx), .o_rdata_c(w_b_rd)
    );

    tournament_predictor_gen2_pht_bank #(.IDX_W(IDX_W), .CTR_W(CTR_W)) u_pht_g (
        .clk(clk), .i_init(w_init), .i_init_idx(r_idx), .i_we(w_upd),
        .i_waddr(w_ug_idx), .i_wdata(w_g_wdata), .i_raddr(w_rg_idx), .o_rdata_c(w_g_rd)
    );

    tournament_predictor_gen2_pht_bank #(.IDX_W(IDX_W), .CTR_W(CTR_W)) u_pht_c (
        .clk(clk), .i_init(w_init), .i_init_idx(r_idx), .i_we(w_c_we),
        .i_waddr(w_ub_idx), .i_wdata(w_c_wdata), .i_raddr(w_rb_idx), .o_rdata_c(w_c_rd)
    );

    assign w_is_dj     = (kind_pdc == KIND_DIRECT_JUMP);
    assign w_is_uncond = kind_pdc inside {KIND_JUMP, KIND_CALL, KIND_RET, KIND_INDIRECT_JUMP};
    assign w_pred_dj   = w_c_rd[MSB] ? w_g_rd[MSB] : w_b_rd[MSB];
    assign w_taken_c   = w_is_uncond | (w_run & w_is_dj & w_pred_dj);

    // Recovery from EX overrides the speculative shift of a same-cycle prediction.
    always_comb begin
        w_ghr_next = r_ghr;
        if (w_run && update_en && mispredict) begin
            w_ghr_next = (kind_ex == KIND_DIRECT_JUMP) ? {ghr_ex[GH_W-2:0], taken_real} : ghr_ex;
        end else if (w_run && pdc_valid && w_is_dj) begin
            w_ghr_next = {r_ghr[GH_W-2:0], w_pred_dj};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ghr     <= '0;
            r_valid_o <= 1'b0;
            r_taken   <= 1'b0;
            r_choice  <= 1'b0;
            r_ctr_b   <= '0;
            r_ctr_g   <= '0;
            r_ctr_c   <= '0;
            r_ghr_o   <= '0;
        end else begin
            r_ghr     <= w_ghr_next;
            r_valid_o <= pdc_valid;
            if (pdc_valid) begin
                r_taken  <= w_taken_c;
                r_ghr_o  <= r_ghr;
                r_choice <= w_run & w_c_rd[MSB];
                r_ctr_b  <= w_run ? w_b_rd : '0;
                r_ctr_g  <= w_run ? w_g_rd : '0;
                r_ctr_c  <= w_run ? w_c_rd : '0;
            end
        end
    end

    assign ready       = r_ready;
    assign pdc_valid_o = r_valid_o;
    assign taken_pdc   = r_taken;
    assign choice_b_g  = r_choice;
    assign ctr_b_o     = r_ctr_b;
    assign ctr_g_o     = r_ctr_g;
    assign ctr_c_o     = r_ctr_c;
    assign ghr_o       = r_ghr_o;

    assign w_unused_ok = ^{pc[ADDR_WIDTH-1:IDX_W], pc_ex[ADDR_WIDTH-1:IDX_W]};

endmodule

// File: tb/tb_tournament_predictor_gen2.sv
// Bench for tournament_predictor_gen2 (16-entry tables): directed steps followed by
// random traffic, every cycle compared against an arithmetic reference model.
module tb_tournament_predictor_gen2;

    localparam int unsigned ADDR_WIDTH = 30;
    localparam int unsigned IDX_W      = 4;
    localparam int unsigned CTR_W      = 2;
    localparam int unsigned GH_W       = 4;
    localparam int N     = 1 << IDX_W;
    localparam int CMAX  = (1 << CTR_W) - 1;
    localparam int HALF  = 1 << (CTR_W - 1);
    localparam int WEAK  = HALF - 1;
    localparam int GMASK = (1 << GH_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  ready;
    logic                  pdc_valid;
    logic [ADDR_WIDTH-1:0] pc;
    logic [2:0]            kind_pdc;
    logic                  pdc_valid_o, taken_pdc, choice_b_g;
    logic [CTR_W-1:0]      ctr_b_o, ctr_g_o, ctr_c_o;
    logic [GH_W-1:0]       ghr_o;
    logic                  update_en;
    logic [ADDR_WIDTH-1:0] pc_ex;
    logic [2:0]            kind_ex;
    logic                  taken_real, mispredict;
    logic [GH_W-1:0]       ghr_ex;
    logic [CTR_W-1:0]      ctr_b_ex, ctr_g_ex, ctr_c_ex;

    tournament_predictor_gen2 #(
        .ADDR_WIDTH(ADDR_WIDTH), .IDX_W(IDX_W), .CTR_W(CTR_W), .GH_W(GH_W)
    ) dut (
        .clk(clk), .rst(rst), .ready(ready),
        .pdc_valid(pdc_valid), .pc(pc), .kind_pdc(kind_pdc),
        .pdc_valid_o(pdc_valid_o), .taken_pdc(taken_pdc), .choice_b_g(choice_b_g),
        .ctr_b_o(ctr_b_o), .ctr_g_o(ctr_g_o), .ctr_c_o(ctr_c_o), .ghr_o(ghr_o),
        .update_en(update_en), .pc_ex(pc_ex), .kind_ex(kind_ex),
        .taken_real(taken_real), .mispredict(mispredict), .ghr_ex(ghr_ex),
        .ctr_b_ex(ctr_b_ex), .ctr_g_ex(ctr_g_ex), .ctr_c_ex(ctr_c_ex)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state: plain integer tables and history.
    int m_b[N], m_g[N], m_c[N];
    int m_ghr, m_idx;
    bit m_ready;
    int m_valid, m_taken, m_choice, m_cb, m_cg, m_cc, m_ghro;

    int exp_chain[3] = '{2, 3, 3};
    int exp_ghr[3]   = '{0, 1, 3};
    int chain_b;

    function automatic int sat(int v, bit up);
        if (up) return (v >= CMAX) ? CMAX : v + 1;
        return (v <= 0) ? 0 : v - 1;
    endfunction

    function automatic bit is_uncond(int k);
        return (k >= 2) && (k <= 5);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_b[i] = WEAK; m_g[i] = WEAK; m_c[i] = WEAK;
        end
        m_ghr = 0; m_idx = 0; m_ready = 1'b0;
        m_valid = 0; m_taken = 0; m_choice = 0;
        m_cb = 0; m_cg = 0; m_cc = 0; m_ghro = 0;
    endtask

    // One clock edge of the reference model, using the inputs currently driven.
    task automatic m_edge();
        int ib, ig, rb, rg, rc;
        bit pred;
        m_valid = int'(pdc_valid);
        if (!m_ready) begin
            if (pdc_valid) begin
                m_taken = is_uncond(int'(kind_pdc));
                m_choice = 0; m_cb = 0; m_cg = 0; m_cc = 0;
                m_ghro = m_ghr;
            end
            m_idx++;
            if (m_idx == N) m_ready = 1'b1;
        end else begin
            if (update_en && kind_ex == 3'd1) begin
                ib = int'(pc_ex) % N;
                ig = ib ^ int'(ghr_ex);
                m_b[ib] = sat(int'(ctr_b_ex), taken_real);
                m_g[ig] = sat(int'(ctr_g_ex), taken_real);
                if ((int'(ctr_b_ex) >= HALF) != (int'(ctr_g_ex) >= HALF))
                    m_c[ib] = sat(int'(ctr_c_ex), (int'(ctr_g_ex) >= HALF) == taken_real);
            end
            ib = int'(pc) % N;
            ig = ib ^ m_ghr;
            rb = m_b[ib]; rg = m_g[ig]; rc = m_c[ib];
            pred = (rc >= HALF) ? (rg >= HALF) : (rb >= HALF);
            if (pdc_valid) begin
                m_taken  = (kind_pdc == 3'd1) ? int'(pred) : int'(is_uncond(int'(kind_pdc)));
                m_choice = int'(rc >= HALF);
                m_cb = rb; m_cg = rg; m_cc = rc;
                m_ghro = m_ghr;
            end
            if (update_en && mispredict)
                m_ghr = (kind_ex == 3'd1) ? ((int'(ghr_ex) * 2 + int'(taken_real)) & GMASK)
                                          : int'(ghr_ex);
            else if (pdc_valid && kind_pdc == 3'd1)
                m_ghr = (m_ghr * 2 + int'(pred)) & GMASK;
        end
    endtask

    task automatic check_all();
        chk("ready", 32'(ready), 32'(m_ready));
        chk("pdc_valid_o", 32'(pdc_valid_o), 32'(m_valid));
        chk("taken_pdc", 32'(taken_pdc), 32'(m_taken));
        chk("choice_b_g", 32'(choice_b_g), 32'(m_choice));
        chk("ctr_b_o", 32'(ctr_b_o), 32'(m_cb));
        chk("ctr_g_o", 32'(ctr_g_o), 32'(m_cg));
        chk("ctr_c_o", 32'(ctr_c_o), 32'(m_cc));
        chk("ghr_o", 32'(ghr_o), 32'(m_ghro));
    endtask

    task automatic cycle();
        @(posedge clk);
        m_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        pdc_valid = 1'b0; update_en = 1'b0; mispredict = 1'b0;
    endtask

    task automatic req(int k, int p);
        pdc_valid = 1'b1; kind_pdc = 3'(k); pc = ADDR_WIDTH'(p);
    endtask

    task automatic upd(int k, int p, bit t, bit mp, int gh, int cb, int cg, int cc);
        update_en = 1'b1; kind_ex = 3'(k); pc_ex = ADDR_WIDTH'(p);
        taken_real = t; mispredict = mp; ghr_ex = GH_W'(gh);
        ctr_b_ex = CTR_W'(cb); ctr_g_ex = CTR_W'(cg); ctr_c_ex = CTR_W'(cc);
    endtask

    task automatic rand_inputs();
        pdc_valid  = 1'($urandom_range(0, 1));
        kind_pdc   = $urandom_range(0, 1) ? 3'd1 : 3'($urandom_range(0, 7));
        pc         = ADDR_WIDTH'($urandom);
        update_en  = 1'($urandom_range(0, 1));
        kind_ex    = $urandom_range(0, 2) != 0 ? 3'd1 : 3'($urandom_range(0, 7));
        pc_ex      = ADDR_WIDTH'($urandom);
        taken_real = 1'($urandom_range(0, 1));
        mispredict = ($urandom_range(0, 3) == 0);
        ghr_ex     = GH_W'($urandom);
        ctr_b_ex   = CTR_W'($urandom);
        ctr_g_ex   = CTR_W'($urandom);
        ctr_c_ex   = CTR_W'($urandom);
    endtask

    initial begin
        idle();
        kind_pdc = 3'd0; pc = '0; kind_ex = 3'd0; pc_ex = '0; taken_real = 1'b0;
        ghr_ex = '0; ctr_b_ex = '0; ctr_g_ex = '0; ctr_c_ex = '0;
        m_reset();

        // Power-on reset, then the sweep with ignored training traffic.
        #1 rst = 1'b1;
        #1;
        check_all();
        chk("rst_ready", 32'(ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 1; i <= N; i++) begin
            rand_inputs();
            cycle();
            chk("sweep_ready", 32'(ready), 32'(i == N));
        end

        // First direction lookup sees the weak-not-taken reset value.
        idle(); req(1, 0);
        cycle();
        chk("dj_pc0_taken", 32'(taken_pdc), 32'd0);
        chk("dj_pc0_ctr_b", 32'(ctr_b_o), 32'(WEAK));

        // Bimodal saturation through chained snapshots, read back via forwarding.
        chain_b = WEAK;
        for (int i = 0; i < 3; i++) begin
            idle(); req(2, 5); upd(1, 5, 1'b1, 1'b0, 0, chain_b, 1, 1);
            cycle();
            chk("sat_chain", 32'(ctr_b_o), 32'(exp_chain[i]));
            chain_b = exp_chain[i];
        end
        idle(); req(1, 5);
        cycle();
        chk("trained_taken", 32'(taken_pdc), 32'd1);

        // Chooser training: only when bimodal and gshare disagree.
        idle(); req(2, 7); upd(1, 7, 1'b1, 1'b0, 0, 3, 0, 1);
        cycle();
        chk("chooser_dec", 32'(ctr_c_o), 32'd0);
        idle(); req(2, 7); upd(1, 7, 1'b0, 1'b0, 0, 3, 0, 1);
        cycle();
        chk("chooser_inc", 32'(ctr_c_o), 32'd2);
        idle(); req(2, 7); upd(1, 7, 1'b0, 1'b0, 0, 3, 3, 0);
        cycle();
        chk("chooser_hold", 32'(ctr_c_o), 32'd2);

        // History: restore to 0, three taken predictions, then DJ recovery.
        idle(); upd(2, 0, 1'b0, 1'b1, 0, 0, 0, 0);
        cycle();
        for (int i = 0; i < 3; i++) begin
            idle(); req(1, 5);
            cycle();
            chk("ghr_seq", 32'(ghr_o), 32'(exp_ghr[i]));
            chk("ghr_seq_taken", 32'(taken_pdc), 32'd1);
        end
        idle(); upd(1, 9, 1'b0, 1'b1, 1, 1, 1, 1);
        cycle();
        idle(); req(1, 5);
        cycle();
        chk("ghr_recover", 32'(ghr_o), 32'd2);

        // Prediction and recovery in the same cycle: recovery value, no extra shift.
        idle(); req(1, 5); upd(1, 11, 1'b1, 1'b1, 4, 1, 1, 1);
        cycle();
        chk("ghr_pre_recover", 32'(ghr_o), 32'd5);
        idle(); req(2, 0);
        cycle();
        chk("ghr_recover_wins", 32'(ghr_o), 32'd9);

        idle(); req(2, 3); upd(1, 3, 1'b1, 1'b0, 0, 2, 1, 1);
        cycle();
        chk("bypass_b", 32'(ctr_b_o), 32'd3);

        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            cycle();
        end

        // Reset in the middle of RUN clears outputs at once and reruns the sweep.
        rand_inputs();
        #3 rst = 1'b1;
        m_reset();
        #1;
        check_all();
        chk("midrun_ready", 32'(ready), 32'd0);
        chk("midrun_valid", 32'(pdc_valid_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 1; i <= N; i++) begin
            rand_inputs();
            cycle();
            chk("resweep_ready", 32'(ready), 32'(i == N));
        end
        idle(); req(2, 5);
        cycle();
        chk("erased_b", 32'(ctr_b_o), 32'(WEAK));
        chk("erased_c", 32'(ctr_c_o), 32'(WEAK));

        for (int i = 0; i < 200; i++) begin
            rand_inputs();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
